// File: rtl/rv32i_decode_exec.sv
// rv32i_decode_exec: ID-stage decode, branch compare and ALU feeding EX/MEM.
// Optional macro DECODE_ILLEGAL_FLAG_EN registers an undefined-opcode flag.
module rv32i_decode_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] ir,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic [1:0]  pc_sel,
  output logic        br_en,
  output logic [31:0] target_address,
  output logic        ex_valid,
  output logic [31:0] ex_alu_out,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic        ex_br_en,
  output logic [4:0]  ex_rd_id,
  output logic [2:0]  ex_funct3,
  output logic        ex_load_regfile,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [2:0]  ex_regfile_sel,
  output logic        ex_illegal
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SLL = 3'd1;
  localparam logic [2:0] ALU_SRA = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_OR  = 3'd6;
  localparam logic [2:0] ALU_AND = 3'd7;

  localparam logic [2:0] CMP_BEQ  = 3'b000;
  localparam logic [2:0] CMP_BNE  = 3'b001;
  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BGE  = 3'b101;
  localparam logic [2:0] CMP_BLTU = 3'b110;
  localparam logic [2:0] CMP_BGEU = 3'b111;

  localparam logic [2:0] RF_ALU = 3'd0;
  localparam logic [2:0] RF_BR  = 3'd1;
  localparam logic [2:0] RF_IMM = 3'd2;
  localparam logic [2:0] RF_LD  = 3'd3;
  localparam logic [2:0] RF_PC4 = 3'd4;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_lui, is_auipc, is_jal, is_jalr;
  logic       is_br, is_load, is_store, is_opi, is_op;

  assign opc      = ir[6:0];
  assign f3       = ir[14:12];
  assign is_lui   = (opc == OP_LUI);
  assign is_auipc = (opc == OP_AUIPC);
  assign is_jal   = (opc == OP_JAL);
  assign is_jalr  = (opc == OP_JALR);
  assign is_br    = (opc == OP_BR);
  assign is_load  = (opc == OP_LOAD);
  assign is_store = (opc == OP_STORE);
  assign is_opi   = (opc == OP_IMM);
  assign is_op    = (opc == OP_REG);

  logic       unused_ir;
  assign unused_ir = ^{ir[31], ir[29:15]};

  logic [2:0] alu_op;
  logic       a_pc;
  logic       b_rs2;
  logic [2:0] cmp_op;
  logic       cmp_rs2;
  logic       wr;
  logic       mr;
  logic       mw;
  logic [2:0] rf_sel;
  logic       known;
  logic [1:0] jmp_sel;
  logic       tgt_rs1;

  // Control-word decode, one opcode class at a time.
  always_comb begin
    alu_op  = ALU_ADD;
    a_pc    = 1'b0;
    b_rs2   = 1'b0;
    cmp_op  = f3;
    cmp_rs2 = 1'b1;
    wr      = 1'b0;
    mr      = 1'b0;
    mw      = 1'b0;
    rf_sel  = RF_ALU;
    known   = 1'b1;
    jmp_sel = 2'b00;
    tgt_rs1 = 1'b0;
    unique case (1'b1)
      is_lui: begin
        wr     = 1'b1;
        rf_sel = RF_IMM;
      end
      is_auipc: begin
        wr   = 1'b1;
        a_pc = 1'b1;
      end
      is_jal: begin
        wr      = 1'b1;
        rf_sel  = RF_PC4;
        jmp_sel = 2'b01;
      end
      is_jalr: begin
        wr      = 1'b1;
        rf_sel  = RF_PC4;
        jmp_sel = 2'b10;
        tgt_rs1 = 1'b1;
      end
      is_br: begin
        cmp_op = f3;
      end
      is_load: begin
        wr     = 1'b1;
        mr     = 1'b1;
        rf_sel = RF_LD;
      end
      is_store: begin
        mw = 1'b1;
      end
      is_opi, is_op: begin
        wr      = 1'b1;
        b_rs2   = is_op;
        cmp_rs2 = is_op;
        cmp_op  = f3[0] ? CMP_BLTU : CMP_BLT;
        unique case (f3)
          3'b000: alu_op = (is_op & ir[30]) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: rf_sel = RF_BR;
          3'b011: rf_sel = RF_BR;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = ir[30] ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: known = 1'b0;
    endcase
  end

  logic [31:0] cmp_b;
  assign cmp_b = cmp_rs2 ? rs2_data : imm;

  // Branch / set-less-than comparator.
  always_comb begin
    br_en = 1'b0;
    unique case (cmp_op)
      CMP_BEQ:  br_en = (rs1_data == cmp_b);
      CMP_BNE:  br_en = (rs1_data != cmp_b);
      CMP_BLT:  br_en = ($signed(rs1_data) < $signed(cmp_b));
      CMP_BGE:  br_en = ($signed(rs1_data) >= $signed(cmp_b));
      CMP_BLTU: br_en = (rs1_data < cmp_b);
      CMP_BGEU: br_en = (rs1_data >= cmp_b);
      default:  br_en = 1'b0;
    endcase
  end

  assign target_address = (tgt_rs1 ? rs1_data : pc) + imm;
  assign pc_sel = !in_valid ? 2'b00 :
                  is_br     ? {1'b0, br_en} :
                              jmp_sel;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic [31:0] alu_y;

  assign alu_a = a_pc ? pc : rs1_data;
  assign alu_b = b_rs2 ? rs2_data : imm;
  assign shamt = alu_b[4:0];

  // Integer ALU.
  always_comb begin
    alu_y = 32'd0;
    unique case (alu_op)
      ALU_ADD: alu_y = alu_a + alu_b;
      ALU_SLL: alu_y = alu_a << shamt;
      ALU_SRA: alu_y = $unsigned($signed(alu_a) >>> shamt);
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_XOR: alu_y = alu_a ^ alu_b;
      ALU_SRL: alu_y = alu_a >> shamt;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      default: alu_y = 32'd0;
    endcase
  end

  logic illegal_d;
`ifdef DECODE_ILLEGAL_FLAG_EN
  assign illegal_d = in_valid & ~known;
`else
  assign illegal_d = 1'b0;
`endif

  // EX/MEM boundary register; a bubble clears all strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid        <= 1'b0;
      ex_alu_out      <= 32'd0;
      ex_pc           <= 32'd0;
      ex_imm          <= 32'd0;
      ex_br_en        <= 1'b0;
      ex_rd_id        <= 5'd0;
      ex_funct3       <= 3'd0;
      ex_load_regfile <= 1'b0;
      ex_mem_read     <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_regfile_sel  <= 3'd0;
      ex_illegal      <= 1'b0;
    end else begin
      ex_valid        <= in_valid;
      ex_alu_out      <= alu_y;
      ex_pc           <= pc;
      ex_imm          <= imm;
      ex_br_en        <= br_en;
      ex_rd_id        <= ir[11:7];
      ex_funct3       <= f3;
      ex_load_regfile <= in_valid & known & wr & (|ir[11:7]);
      ex_mem_read     <= in_valid & mr;
      ex_mem_write    <= in_valid & mw;
      ex_regfile_sel  <= rf_sel;
      ex_illegal      <= illegal_d;
    end
  end

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// tb_rv32i_decode_exec: directed plus random checks of rv32i_decode_exec
// against an instruction-level reference model.
module tb_rv32i_decode_exec;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] ir, pc, rs1_data, rs2_data, imm;
  logic [1:0]  pc_sel;
  logic        br_en;
  logic [31:0] target_address;
  logic        ex_valid;
  logic [31:0] ex_alu_out, ex_pc, ex_imm;
  logic        ex_br_en;
  logic [4:0]  ex_rd_id;
  logic [2:0]  ex_funct3;
  logic        ex_load_regfile, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_regfile_sel;
  logic        ex_illegal;

  int checks = 0;
  int errors = 0;

  rv32i_decode_exec dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ir(ir), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .pc_sel(pc_sel), .br_en(br_en), .target_address(target_address),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_br_en(ex_br_en), .ex_rd_id(ex_rd_id),
    .ex_funct3(ex_funct3), .ex_load_regfile(ex_load_regfile),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_regfile_sel(ex_regfile_sel), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  pc_sel;
    logic        br;
    logic        br_def;
    logic [31:0] tgt;
    logic        tgt_def;
    logic [31:0] alu;
    logic        alu_def;
    logic        wr;
    logic        ld;
    logic        mr;
    logic        mw;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  // Instruction-level behaviour, mnemonic by mnemonic.
  function automatic exp_t model(input logic v, input logic [31:0] i,
                                 input logic [31:0] p, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] im);
    exp_t e;
    logic [2:0]  fn;
    logic [31:0] r;
    fn = i[14:12];
    e = '{pc_sel: 2'b00, br: 1'b0, br_def: 1'b0, tgt: 32'd0, tgt_def: 1'b0,
          alu: 32'd0, alu_def: 1'b0, wr: 1'b0, ld: 1'b0, mr: 1'b0,
          mw: 1'b0, sel: 3'd0, ill: 1'b0};
    case (i[6:0])
      7'h37: begin e.wr = 1; e.sel = 2; end
      7'h17: begin e.wr = 1; e.alu = p + im; e.alu_def = 1; end
      7'h6F: begin
        e.wr = 1; e.sel = 4; e.pc_sel = 1;
        e.tgt = p + im; e.tgt_def = 1;
      end
      7'h67: begin
        e.wr = 1; e.sel = 4; e.pc_sel = 2;
        e.tgt = a + im; e.tgt_def = 1;
      end
      7'h63: begin
        e.br_def = 1;
        case (fn)
          0: e.br = (a == b);
          1: e.br = (a != b);
          4: e.br = ($signed(a) < $signed(b));
          5: e.br = !($signed(a) < $signed(b));
          6: e.br = (a < b);
          default: e.br = !(a < b);
        endcase
        e.pc_sel = e.br ? 2'b01 : 2'b00;
        e.tgt = p + im; e.tgt_def = 1;
      end
      7'h03: begin
        e.wr = 1; e.mr = 1; e.sel = 3;
        e.alu = a + im; e.alu_def = 1;
      end
      7'h23: begin e.mw = 1; e.alu = a + im; e.alu_def = 1; end
      7'h13, 7'h33: begin
        r = (i[6:0] == 7'h33) ? b : im;
        e.wr = 1; e.alu_def = 1;
        case (fn)
          0: e.alu = (i[6:0] == 7'h33 && i[30]) ? a - r : a + r;
          1: e.alu = a << r[4:0];
          2: begin
            e.alu_def = 0; e.sel = 1; e.br_def = 1;
            e.br = ($signed(a) < $signed(r));
          end
          3: begin
            e.alu_def = 0; e.sel = 1; e.br_def = 1;
            e.br = (a < r);
          end
          4: e.alu = a ^ r;
          5: e.alu = i[30] ? $unsigned($signed(a) >>> r[4:0]) : a >> r[4:0];
          6: e.alu = a | r;
          default: e.alu = a & r;
        endcase
      end
      default: e.ill = 1;
    endcase
`ifndef DECODE_ILLEGAL_FLAG_EN
    e.ill = 0;
`endif
    if (!v) begin
      e.pc_sel = 0; e.mr = 0; e.mw = 0; e.ill = 0;
    end
    e.ld = v && e.wr && (i[11:7] != 0);
    return e;
  endfunction

  // Drive one instruction, check the same-cycle and registered outputs.
  task automatic run(input logic v, input logic [31:0] i, input logic [31:0] p,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] im);
    exp_t e;
    e = model(v, i, p, a, b, im);
    @(negedge clk);
    in_valid = v; ir = i; pc = p; rs1_data = a; rs2_data = b; imm = im;
    #1;
    check("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
    if (e.br_def) check("br_en", 32'(br_en), 32'(e.br));
    if (e.tgt_def) check("target", target_address, e.tgt);
    @(posedge clk);
    #1;
    check("ex_valid", 32'(ex_valid), 32'(v));
    check("ex_pc", ex_pc, p);
    check("ex_imm", ex_imm, im);
    check("ex_rd", 32'(ex_rd_id), 32'(i[11:7]));
    check("ex_f3", 32'(ex_funct3), 32'(i[14:12]));
    check("ex_ld_rf", 32'(ex_load_regfile), 32'(e.ld));
    check("ex_mrd", 32'(ex_mem_read), 32'(e.mr));
    check("ex_mwr", 32'(ex_mem_write), 32'(e.mw));
    check("ex_ill", 32'(ex_illegal), 32'(e.ill));
    if (e.alu_def) check("ex_alu", ex_alu_out, e.alu);
    if (e.br_def) check("ex_br_en", 32'(ex_br_en), 32'(e.br));
    if (e.wr) check("ex_rf_sel", 32'(ex_regfile_sel), 32'(e.sel));
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(3))
      0: return $urandom;
      1: return 32'($urandom_range(15));
      2: return 32'h8000_0000 | 32'($urandom_range(15));
      default: return 32'hFFFF_FFFF - 32'($urandom_range(15));
    endcase
  endfunction

  task automatic check_ex_zero(input string tag);
    check({tag, "_alu"}, ex_alu_out, 32'd0);
    check({tag, "_pc"}, ex_pc, 32'd0);
    check({tag, "_imm"}, ex_imm, 32'd0);
    check({tag, "_ctl"},
          32'({ex_valid, ex_br_en, ex_rd_id, ex_funct3, ex_load_regfile,
               ex_mem_read, ex_mem_write, ex_regfile_sel, ex_illegal}),
          32'd0);
  endtask

  logic [6:0] opcs [10];

  initial begin
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
             7'h33, 7'h73};
    rst = 1'b0;
    in_valid = 1'b0; ir = '0; pc = '0;
    rs1_data = '0; rs2_data = '0; imm = '0;
    #2;
    check_ex_zero("rst0");
    @(negedge clk);
    rst = 1'b1;

    // add x5, x6, x7
    run(1, 32'h007302B3, 32'h40, 5, 7, 0);
    check("add_alu", ex_alu_out, 32'd12);
    check("add_rd", 32'(ex_rd_id), 32'd5);
    check("add_ld", 32'(ex_load_regfile), 32'd1);
    check("add_sel", 32'(ex_regfile_sel), 32'd0);

    // sub x1, x2, x3 and srai x1, x2, 4
    run(1, 32'h403100B3, 32'h44, 3, 5, 0);
    check("sub_alu", ex_alu_out, 32'hFFFF_FFFE);
    run(1, 32'h40415093, 32'h48, 32'h8000_0000, 0, 32'h404);
    check("srai_alu", ex_alu_out, 32'hF800_0000);

    // beq taken / not taken
    run(1, 32'h00000063, 32'h100, 9, 9, 32'h20);
    check("beq_br", 32'(br_en), 32'd1);
    check("beq_sel", 32'(pc_sel), 32'd1);
    check("beq_tgt", target_address, 32'h120);
    run(1, 32'h00000063, 32'h100, 9, 8, 32'h20);
    check("bne_sel", 32'(pc_sel), 32'd0);

    // jalr x1, 0(x1)
    run(1, 32'h000080E7, 32'h200, 32'h203, 0, 0);
    check("jalr_sel", 32'(pc_sel), 32'd2);
    check("jalr_tgt", target_address, 32'h203);
    check("jalr_rf", 32'(ex_regfile_sel), 32'd4);

    // sltu and slt
    run(1, 32'h003130B3, 32'h300, 32'hFFFF_FFFF, 1, 0);
    check("sltu_br", 32'(br_en), 32'd0);
    check("sltu_rf", 32'(ex_regfile_sel), 32'd1);
    run(1, 32'h003120B3, 32'h304, 32'hFFFF_FFFF, 1, 0);
    check("slt_br", 32'(br_en), 32'd1);
    check("slt_rf", 32'(ex_regfile_sel), 32'd1);

    // Bubble of a load, and rd = 0 write suppression
    run(0, 32'h00002083, 32'h308, 4, 0, 8);
    run(1, 32'h00000013, 32'h30C, 1, 0, 1);

    // Undefined opcode
    run(1, 32'h00000FFF, 32'h310, 1, 2, 3);
`ifdef DECODE_ILLEGAL_FLAG_EN
    check("ill_flag", 32'(ex_illegal), 32'd1);
`else
    check("ill_flag", 32'(ex_illegal), 32'd0);
`endif
    check("ill_ld", 32'(ex_load_regfile), 32'd0);

    // Asynchronous reset between edges
    run(1, 32'h007302B3, 32'h314, 5, 7, 1);
    #2;
    rst = 1'b0;
    #1;
    check_ex_zero("rst_mid");
    @(negedge clk);
    #1;
    check_ex_zero("rst_hold");
    rst = 1'b1;
    #1;
    check_ex_zero("rst_rel");

    // Random instruction stream
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ri, ra, rb;
      logic [6:0]  op;
      ri = $urandom;
      op = ($urandom_range(9) == 0) ? 7'($urandom) : opcs[$urandom_range(9)];
      ri[6:0] = op;
      if (op == 7'h63 && ri[13]) ri[14] = 1'b1;
      if ($urandom_range(3) == 0) ri[11:7] = 5'd0;
      ra = pick32();
      rb = ($urandom_range(2) == 0) ? ra : pick32();
      run($urandom_range(4) != 0, ri, $urandom, ra, rb, pick32());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32i_decode_exec.md
# rv32i_decode_exec

RV32I decode/compare/execute slice of the five-stage pipeline. It combines three functions:
- Control-word generation from the instruction word.
- Branch comparison and next-PC select, resolved in the decode stage.
- The integer ALU.

Decode and compare are combinational in the ID stage. ALU result and forwarded control are registered once into the EX/MEM boundary.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the ID-stage instruction is real. When 0, the instruction is a bubble.
- `ir` in 32: ID-stage instruction.
- `pc` in 32: PC of `ir`.
- `rs1_data`, `rs2_data` in 32: register operands, already forwarded.
- `imm` in 32: immediate, already sign-extended per format.
- `pc_sel` out 2: next-PC select. 00 = pc+4; 01 = target; 10 = target with bit 0 cleared.
- `br_en` out 1: compare result.
- `target_address` out 32: branch/jump target.
- `ex_valid` out 1: registered `in_valid`.
- `ex_alu_out` out 32: registered ALU result.
- `ex_pc` out 32: registered `pc`.
- `ex_imm` out 32: registered `imm`.
- `ex_br_en` out 1: registered `br_en`.
- `ex_rd_id` out 5: registered `ir[11:7]`.
- `ex_funct3` out 3: registered `ir[14:12]`.
- `ex_load_regfile` out 1: registered register-write enable.
- `ex_mem_read`, `ex_mem_write` out 1: registered memory strobes.
- `ex_regfile_sel` out 3: registered writeback select. 0 = alu_out, 1 = br_en, 2 = imm, 3 = load, 4 = pc_plus4.
- `ex_illegal` out 1: registered undefined-opcode flag.

## Operation
- ALU op encoding (3-bit): add 0, sll 1, sra 2, sub 3, xor 4, srl 5, or 6, and 7.
- Shift amount is `b[4:0]`. `sra` is arithmetic.
- Compare op from funct3:
  - beq 000, bne 001: equality tests.
  - blt 100, bge 101: signed.
  - bltu 110, bgeu 111: unsigned.
- Decode by `ir[6:0]`:
  - **lui** 0110111: sel imm.
  - **auipc** 0010111: ALU pc + imm; sel alu_out.
  - **jal** 1101111: target = pc + imm; `pc_sel` 01; sel pc_plus4.
  - **jalr** 1100111: target = rs1 + imm; `pc_sel` 10; sel pc_plus4.
  - **branch** 1100011: cmp rs1 vs rs2 using the funct3 op; `pc_sel` = 01 if `br_en`, else 00. Target = pc + imm. No register write.
  - **load** 0000011: ALU rs1 + imm; mem_read; sel load.
  - **store** 0100011: ALU rs1 + imm; mem_write; no register write.
  - **op-imm** 0010011: ALU rs1 vs imm, op from funct3.
    - funct3 101 selects sra if `ir[30]`, else srl.
    - slti (010) and sltiu (011) use cmp blt/bltu with b = imm; sel br_en.
  - **op** 0110011: same as op-imm but b = rs2.
    - funct3 000 selects sub if `ir[30]`, else add.
    - slt/sltu compare against rs2.
- Any other opcode (including 1110011 system):
  - Treated as a NOP: no write, no memory access, `pc_sel` 00.
  - Illegal flag set; see Configuration.
- `ex_load_regfile` is forced to 0 when rd = 0.
- When `in_valid` = 0:
  - `pc_sel` = 00.
  - Registered stage captures a bubble: `ex_valid`, `ex_load_regfile`, `ex_mem_read`, `ex_mem_write`, `ex_illegal` all 0.
- `br_en` is driven for every opcode. It is meaningful only for branch, slt and sltu.
- Arithmetic is 32-bit and wraps. Overflow is ignored.

## Timing
- `pc_sel`, `br_en`, `target_address`: combinational from the inputs, same cycle.
- All `ex_*` outputs: one-cycle latency, updated on every rising edge. There is no stall input.
- `rst` low: all `ex_*` outputs are 0 immediately, independent of `clk`, and stay 0 until the first edge after release.
- Reset mid-operation discards the in-flight instruction.

## Configuration
- Macro: `DECODE_ILLEGAL_FLAG_EN`.
- Defined: an undefined opcode with `in_valid` = 1 registers `ex_illegal` = 1.
- Undefined: `ex_illegal` is tied to 0. NOP behaviour is unchanged.

## Test plan
1. add: `ir` = 0x007302B3, rs1 = 5, rs2 = 7 → next edge `ex_alu_out` = 12, `ex_rd_id` = 5, `ex_load_regfile` = 1, `ex_regfile_sel` = 0.
2. sub/srai:
   - sub with rs1 = 3, rs2 = 5 → `ex_alu_out` = 0xFFFFFFFE.
   - srai with rs1 = 0x80000000, shamt 4 → 0xF8000000.
3. beq:
   - pc = 0x100, imm = 0x20, rs1 = rs2 = 9 → `br_en` = 1, `pc_sel` = 01, `target_address` = 0x120 (same cycle).
   - rs2 = 8 → `pc_sel` = 00.
4. jalr, rs1 = 0x203, imm = 0 → `pc_sel` = 10, `target_address` = 0x203, `ex_regfile_sel` = 4.
5. sltu vs slt with rs1 = 0xFFFFFFFF, rs2 = 1 → sltu `br_en` = 0, slt `br_en` = 1; `ex_regfile_sel` = 1.
6. Reset and illegal:
   - Assert `rst` low mid-stream between edges → all `ex_*` outputs 0 immediately.
   - With the macro defined, opcode 0x7F → `ex_illegal` = 1, `ex_load_regfile` = 0.
